parking_gate_controller: RTL and testbench

Sequences the single shared parking gate between the entry and exit sensors and owns the 4-slot occupancy map. It arbitrates simultaneous entry/exit requests, allocates the lowest-numbered free slot to entering cars, frees the slot selected by `switch` on exit, and times the door-open interval. Its outputs drive the status lights and the seven-segment display logic.

---
 rtl/parking_gate_controller_if.sv | 26 ++
 rtl/parking_gate_controller.sv | 125 ++++++++++++
 tb/tb_parking_gate_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_controller_if.sv
// Request/status bundle between the gate sensors, the controller and the display logic.
interface parking_gate_controller_if;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [1:0] switch;
    logic [3:0] parking_slots;
    logic       door_open_light;
    logic       full_light;
    logic [2:0] capacity;
    logic [2:0] best_place;
    logic       grant_entry;
    logic       grant_exit;
    logic       reject;

    modport master (
        output entry_sensor, exit_sensor, switch,
        input  parking_slots, door_open_light, full_light, capacity, best_place,
        input  grant_entry, grant_exit, reject
    );

    modport slave (
        input  entry_sensor, exit_sensor, switch,
        output parking_slots, door_open_light, full_light, capacity, best_place,
        output grant_entry, grant_exit, reject
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Shared parking gate sequencer and 4-slot occupancy map.
// Define PARKING_ROUND_ROBIN_EN to alternate simultaneous requests; otherwise exit wins ties.
module parking_gate_controller #(
    parameter int unsigned DOOR_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    parking_gate_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

    state_t     state_q;
    logic [3:0] slots_q, slots_d;
    logic [3:0] door_cnt_q;
    logic       door_q;
    logic       grant_entry_q, grant_exit_q, reject_q;

    logic [3:0] free_mask;
    logic [2:0] best_place;
    logic [2:0] capacity;
    logic       entry_wins_tie;
    logic       serve_entry, serve_exit, accept, refuse;

`ifdef PARKING_ROUND_ROBIN_EN
    typedef enum logic {DIR_ENTRY, DIR_EXIT} dir_t;
    dir_t last_dir_q;

    assign entry_wins_tie = (last_dir_q == DIR_EXIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dir_q <= DIR_EXIT;
        end else if (state_q == IDLE && accept) begin
            last_dir_q <= serve_entry ? DIR_ENTRY : DIR_EXIT;
        end
    end
`else
    assign entry_wins_tie = 1'b0;
`endif

    // free_mask is one-hot on the lowest free slot, all-zero when the lot is full
    always_comb begin
        free_mask  = '0;
        best_place = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!slots_q[i-1]) begin
                free_mask        = '0;
                free_mask[i-1]   = 1'b1;
                best_place       = 3'(i);
            end
        end
        capacity = 3'd4;
        for (int unsigned i = 0; i < 4; i++) begin
            capacity = capacity - 3'(slots_q[i]);
        end
    end

    // A refused winner blocks the loser for that cycle: only one side is ever served
    always_comb begin
        serve_entry = bus.entry_sensor && (!bus.exit_sensor || entry_wins_tie);
        serve_exit  = bus.exit_sensor && !serve_entry;
        accept      = (serve_entry && (free_mask != '0)) ||
                      (serve_exit && slots_q[bus.switch]);
        refuse      = (serve_entry || serve_exit) && !accept;
        slots_d     = slots_q;
        if (serve_entry) begin
            slots_d = slots_q | free_mask;
        end else if (serve_exit) begin
            slots_d = slots_q & ~(4'b0001 << bus.switch);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slots_q       <= '0;
            door_cnt_q    <= '0;
            door_q        <= 1'b0;
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            reject_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q       <= OPEN;
                        slots_q       <= slots_d;
                        door_q        <= 1'b1;
                        door_cnt_q    <= 4'(DOOR_CYCLES - 1);
                        grant_entry_q <= serve_entry;
                        grant_exit_q  <= serve_exit;
                    end
                    reject_q <= refuse;
                end
                OPEN: begin
                    if (door_cnt_q == '0) begin
                        state_q <= CLOSE;
                        door_q  <= 1'b0;
                    end else begin
                        door_cnt_q <= door_cnt_q - 4'd1;
                    end
                end
                CLOSE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    door_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.parking_slots   = slots_q;
    assign bus.door_open_light = door_q;
    assign bus.full_light      = (slots_q == 4'b1111);
    assign bus.capacity        = capacity;
    assign bus.best_place      = best_place;
    assign bus.grant_entry     = grant_entry_q;
    assign bus.grant_exit      = grant_exit_q;
    assign bus.reject          = reject_q;
endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller; works with or without PARKING_ROUND_ROBIN_EN.
module tb_parking_gate_controller;
    localparam int unsigned DOOR_CYCLES = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parking_gate_controller_if bus ();

    parking_gate_controller #(.DOOR_CYCLES(DOOR_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] slots;
        logic [4:0] busy;
        logic       last_exit;
        logic       ge;
        logic       gx;
        logic       rj;
    } model_t;

    localparam model_t MODEL_RESET = '{slots: 4'b0, busy: 5'd0, last_exit: 1'b1,
                                       ge: 1'b0, gx: 1'b0, rj: 1'b0};

    int passed = 0;
    int total  = 0;
    logic [14:0] sb[$];
    logic [14:0] exp_v;
    logic [14:0] obs;
    model_t m;

    assign obs = {bus.parking_slots, bus.door_open_light, bus.full_light, bus.capacity,
                  bus.best_place, bus.grant_entry, bus.grant_exit, bus.reject};

    // busy = cycles left until the gate is back in IDLE; door is open while busy >= 2
    function automatic logic [14:0] expect_of(model_t s);
        logic [2:0] bp = 3'd0;
        for (int i = 0; i < 4; i++) if (!s.slots[i] && bp == 3'd0) bp = 3'(i + 1);
        return {s.slots, (s.busy >= 5'd2), (s.slots == 4'hF),
                3'(4 - $countones(s.slots)), bp, s.ge, s.gx, s.rj};
    endfunction

    function automatic model_t model_next(model_t c, logic en, logic ex, logic [1:0] sw);
        model_t n = c;
        logic tie_to_entry;
        logic placed = 1'b0;
`ifdef PARKING_ROUND_ROBIN_EN
        tie_to_entry = c.last_exit;
`else
        tie_to_entry = 1'b0;
`endif
        n.ge = 1'b0; n.gx = 1'b0; n.rj = 1'b0;
        if (c.busy != 5'd0) begin
            n.busy = c.busy - 5'd1;
            return n;
        end
        if (en && (!ex || tie_to_entry)) begin
            if (c.slots == 4'hF) n.rj = 1'b1;
            else begin
                for (int i = 0; i < 4; i++)
                    if (!c.slots[i] && !placed) begin n.slots[i] = 1'b1; placed = 1'b1; end
                n.ge = 1'b1; n.busy = 5'(DOOR_CYCLES + 1); n.last_exit = 1'b0;
            end
        end else if (ex) begin
            if (c.slots[sw]) begin
                n.slots[sw] = 1'b0; n.gx = 1'b1; n.busy = 5'(DOOR_CYCLES + 1); n.last_exit = 1'b1;
            end else n.rj = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= MODEL_RESET;
            sb.delete();
            sb.push_back(expect_of(MODEL_RESET));
        end else begin
            sb.push_back(expect_of(model_next(m, bus.entry_sensor, bus.exit_sensor, bus.switch)));
            m <= model_next(m, bus.entry_sensor, bus.exit_sensor, bus.switch);
        end
    end

    task automatic test_reset();
        bus.entry_sensor = 1'b0; bus.exit_sensor = 1'b0; bus.switch = 2'd0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) $display("FAIL reset_sb: no expected entry at %0t", $time);
            else begin
                exp_v = sb.pop_front();
                if (obs !== exp_v) $display("FAIL reset_sb: got %h expected %h", obs, exp_v);
                else passed++;
            end
        end
        total++;
        if (bus.capacity !== 3'd4) $display("FAIL reset_capacity: got %0d expected 4", bus.capacity);
        else passed++;
        total++;
        if (bus.best_place !== 3'd1) $display("FAIL reset_best_place: got %0d expected 1", bus.best_place);
        else passed++;
        total++;
        if ({bus.parking_slots, bus.door_open_light, bus.grant_entry, bus.grant_exit, bus.reject} !== 8'h00)
            $display("FAIL reset_outputs: slots=%b door=%b ge=%b gx=%b rj=%b expected all zero",
                     bus.parking_slots, bus.door_open_light, bus.grant_entry, bus.grant_exit, bus.reject);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        bus.entry_sensor = 1'b1;
        repeat (19) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) $display("FAIL fill_sb: no expected entry at %0t", $time);
            else begin
                exp_v = sb.pop_front();
                if (obs !== exp_v) $display("FAIL fill_sb: got %h expected %h", obs, exp_v);
                else passed++;
            end
        end
        total++;
        if ({bus.parking_slots, bus.full_light, bus.capacity, bus.best_place} !== {4'hF, 1'b1, 3'd0, 3'd0})
            $display("FAIL fill_full: slots=%b full=%b cap=%0d best=%0d expected 1111/1/0/0",
                     bus.parking_slots, bus.full_light, bus.capacity, bus.best_place);
        else passed++;
    endtask

    task automatic test_full_reject();
        repeat (6) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) $display("FAIL full_reject_sb: no expected entry at %0t", $time);
            else begin
                exp_v = sb.pop_front();
                if (obs !== exp_v) $display("FAIL full_reject_sb: got %h expected %h", obs, exp_v);
                else passed++;
            end
        end
        total++;
        if ({bus.reject, bus.door_open_light} !== 2'b10)
            $display("FAIL full_reject: reject=%b door=%b expected 1/0", bus.reject, bus.door_open_light);
        else passed++;
        bus.entry_sensor = 1'b0;
    endtask

    task automatic test_exit();
        // {entry, exit, switch, cycles}: inputs held for the first cycle only
        logic [5:0] phases [5] = '{{1'b0, 1'b1, 2'd3, 2'd0}, {1'b0, 1'b1, 2'd1, 2'd0},
                                   {1'b0, 1'b1, 2'd3, 2'd1}, {1'b1, 1'b0, 2'd0, 2'd0},
                                   {1'b0, 1'b1, 2'd2, 2'd0}};
        for (int p = 0; p < 5; p++) begin
            {bus.entry_sensor, bus.exit_sensor, bus.switch} = phases[p][5:2];
            for (int c = 0; c < ((phases[p][1:0] == 2'd1) ? 1 : 5); c++) begin
                @(negedge clk);
                total++;
                if (sb.size() == 0) $display("FAIL exit_sb: no expected entry at %0t", $time);
                else begin
                    exp_v = sb.pop_front();
                    if (obs !== exp_v) $display("FAIL exit_sb: phase %0d got %h expected %h", p, obs, exp_v);
                    else passed++;
                end
                bus.entry_sensor = 1'b0; bus.exit_sensor = 1'b0;
            end
            if (p == 1) begin
                total++;
                if ({bus.parking_slots, bus.best_place, bus.capacity} !== {4'b0101, 3'd2, 3'd2})
                    $display("FAIL exit_slot1: slots=%b best=%0d cap=%0d expected 0101/2/2",
                             bus.parking_slots, bus.best_place, bus.capacity);
                else passed++;
            end
            if (p == 2) begin
                total++;
                if ({bus.reject, bus.parking_slots} !== {1'b1, 4'b0101})
                    $display("FAIL exit_empty: reject=%b slots=%b expected 1/0101", bus.reject, bus.parking_slots);
                else passed++;
            end
        end
        total++;
        if (bus.parking_slots !== 4'b0011)
            $display("FAIL exit_setup: slots=%b expected 0011", bus.parking_slots);
        else passed++;
    endtask

    task automatic test_tie();
        int n_ge = 0;
        int n_gx = 0;
        logic first_is_exit = 1'b0;
        logic seen = 1'b0;
        bus.entry_sensor = 1'b1; bus.exit_sensor = 1'b1; bus.switch = 2'd0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) $display("FAIL tie_sb: no expected entry at %0t", $time);
            else begin
                exp_v = sb.pop_front();
                if (obs !== exp_v) $display("FAIL tie_sb: got %h expected %h", obs, exp_v);
                else passed++;
            end
            if (bus.grant_entry) n_ge++;
            if (bus.grant_exit) n_gx++;
            if ((bus.grant_entry || bus.grant_exit) && !seen) begin seen = 1'b1; first_is_exit = bus.grant_exit; end
            if (c == 14) begin bus.entry_sensor = 1'b0; bus.exit_sensor = 1'b0; end
        end
        total++;
`ifdef PARKING_ROUND_ROBIN_EN
        if ({n_ge[3:0], n_gx[3:0], first_is_exit, bus.parking_slots} !== {4'd2, 4'd1, 1'b0, 4'b0111})
`else
        if ({n_ge[3:0], n_gx[3:0], first_is_exit, bus.parking_slots} !== {4'd0, 4'd1, 1'b1, 4'b0010})
`endif
            $display("FAIL tie_order: entries=%0d exits=%0d first_exit=%b slots=%b", n_ge, n_gx,
                     first_is_exit, bus.parking_slots);
        else passed++;
    endtask

    task automatic test_reset_mid_open();
        logic granted = 1'b0;
        bus.entry_sensor = 1'b1;
        for (int c = 0; c < 10 && !granted; c++) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) $display("FAIL midreset_sb: no expected entry at %0t", $time);
            else begin
                exp_v = sb.pop_front();
                if (obs !== exp_v) $display("FAIL midreset_sb: got %h expected %h", obs, exp_v);
                else passed++;
            end
            granted = bus.grant_entry;
        end
        total++;
        if (!granted) $display("FAIL midreset_grant_wait: got no grant_entry expected one within 10 cycles");
        else passed++;
        @(negedge clk);
        total++;
        if (sb.size() == 0) $display("FAIL midreset_sb: no expected entry at %0t", $time);
        else begin
            exp_v = sb.pop_front();
            if (obs !== exp_v) $display("FAIL midreset_open2: got %h expected %h", obs, exp_v);
            else passed++;
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.door_open_light, bus.parking_slots, bus.capacity} !== {1'b0, 4'b0000, 3'd4})
            $display("FAIL midreset_async: door=%b slots=%b cap=%0d expected 0/0000/4",
                     bus.door_open_light, bus.parking_slots, bus.capacity);
        else passed++;
        @(negedge clk);
        total++;
        if (sb.size() == 0) $display("FAIL midreset_sb: no expected entry at %0t", $time);
        else begin
            exp_v = sb.pop_front();
            if (obs !== exp_v) $display("FAIL midreset_held: got %h expected %h", obs, exp_v);
            else passed++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (sb.size() == 0) $display("FAIL midreset_sb: no expected entry at %0t", $time);
            else begin
                exp_v = sb.pop_front();
                if (obs !== exp_v) $display("FAIL midreset_after: got %h expected %h", obs, exp_v);
                else passed++;
            end
            if (c == 0) begin
                total++;
                if ({bus.grant_entry, bus.parking_slots} !== {1'b1, 4'b0001})
                    $display("FAIL midreset_first_edge: ge=%b slots=%b expected 1/0001",
                             bus.grant_entry, bus.parking_slots);
                else passed++;
                bus.entry_sensor = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_reject();
        test_exit();
        test_tie();
        test_reset_mid_open();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
